// File: rtl/mips_datapath_register_file_pkg.sv
// -----------------------------------------------------------------------------
// mips_datapath_register_file_pkg
//   Shared MIPS datapath types used by the register file and its scoreboard.
//   Contents:
//     WORD_W, REG_COUNT, ADDR_W, PEND_W   - geometry of the register file
//     Word_T, RegAddr_T                   - data word and register address
//     Mips_Type_RegAddr_Zero              - the hardwired zero register
//     WbSrc_T                             - writeback data source selector
//     RegPorts_T / RegPorts_W             - decode port bundle, structured/flat
//     Mips_Type_RegPorts_pack/unpack      - conversions between the two forms
// -----------------------------------------------------------------------------
package mips_datapath_register_file_pkg;

   localparam int WORD_W    = 32;
   localparam int REG_COUNT = 32;
   localparam int ADDR_W    = $clog2(REG_COUNT);
   localparam int PEND_W    = 2;

   typedef logic [WORD_W-1:0] Word_T;
   typedef logic [ADDR_W-1:0] RegAddr_T;

   localparam RegAddr_T Mips_Type_RegAddr_Zero = '0;

   // Selects which datapath value the writeback mux commits.
   typedef enum logic [1:0] {
      WB_SRC_ALU  = 2'd0,
      WB_SRC_MEM  = 2'd1,
      WB_SRC_LINK = 2'd2,
      WB_SRC_IMM  = 2'd3
   } WbSrc_T;

   typedef struct packed {
      RegAddr_T read1Addr;
      RegAddr_T read2Addr;
      RegAddr_T writeAddr;
      WbSrc_T   writeSrc;
      logic     writeEn;
   } RegPorts_T;

   localparam int REG_PORTS_W = $bits(RegPorts_T);
   typedef logic [REG_PORTS_W-1:0] RegPorts_W;

   function automatic RegPorts_T Mips_Type_RegPorts_unpack(input RegPorts_W flat);
      return RegPorts_T'(flat);
   endfunction

   function automatic RegPorts_W Mips_Type_RegPorts_pack(input RegPorts_T fields);
      return RegPorts_W'(fields);
   endfunction

endpackage

// File: rtl/mips_datapath_register_file_if.sv
// -----------------------------------------------------------------------------
// mips_datapath_register_file_if
//   Bus between decode/writeback (master) and the register file (slave).
//   master drives : ports (RegPorts bundle), issue, wbEn, wbAddr, wbData
//   slave drives  : rd1Data, rd2Data, stall, overflow, writeSrc
//   writeSrc is the bundle's writeback source forwarded to the writeback mux.
// -----------------------------------------------------------------------------
interface mips_datapath_register_file_if;
   import mips_datapath_register_file_pkg::*;

   RegPorts_W ports;
   logic      issue;
   logic      wbEn;
   RegAddr_T  wbAddr;
   Word_T     wbData;
   Word_T     rd1Data;
   Word_T     rd2Data;
   logic      stall;
   logic      overflow;
   WbSrc_T    writeSrc;

   modport master (
      output ports, issue, wbEn, wbAddr, wbData,
      input  rd1Data, rd2Data, stall, overflow, writeSrc
   );

   modport slave (
      input  ports, issue, wbEn, wbAddr, wbData,
      output rd1Data, rd2Data, stall, overflow, writeSrc
   );

endinterface

// File: rtl/mips_datapath_register_scoreboard.sv
// -----------------------------------------------------------------------------
// mips_datapath_register_scoreboard
//   Per-register count of in-flight writes, used by decode to stall on RAW
//   hazards. Register 0 never accumulates pending writes and never stalls.
//   Ports:
//     clock, reset_n            - rising-edge clock, async active-low reset
//     read1Addr, read2Addr      - source registers of the instruction in decode
//     writeAddr, writeEn, issue - destination of the instruction leaving decode
//     wbEn, wbAddr              - writeback commit retiring one pending write
//     stall                     - RAW hazard on either read address
//     overflow                  - sticky: an issue found its counter saturated
// -----------------------------------------------------------------------------
module mips_datapath_register_scoreboard #(
   parameter int PEND_W = mips_datapath_register_file_pkg::PEND_W
) (
   input  logic                                      clock,
   input  logic                                      reset_n,
   input  mips_datapath_register_file_pkg::RegAddr_T read1Addr,
   input  mips_datapath_register_file_pkg::RegAddr_T read2Addr,
   input  mips_datapath_register_file_pkg::RegAddr_T writeAddr,
   input  logic                                      writeEn,
   input  logic                                      issue,
   input  logic                                      wbEn,
   input  mips_datapath_register_file_pkg::RegAddr_T wbAddr,
   output logic                                      stall,
   output logic                                      overflow
);
   import mips_datapath_register_file_pkg::REG_COUNT;
   import mips_datapath_register_file_pkg::RegAddr_T;
   import mips_datapath_register_file_pkg::Mips_Type_RegAddr_Zero;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [PEND_W-1:0]    pending [REG_COUNT];
   logic [REG_COUNT-1:0] inc;
   logic [REG_COUNT-1:0] dec;
   logic [REG_COUNT-1:0] sat_hit;
   logic                 hz1;
   logic                 hz2;

   // A read is released as soon as its last outstanding write is being
   // committed this cycle; the top-level bypass supplies that value.
   always_comb begin
      hz1 = (read1Addr != Mips_Type_RegAddr_Zero) && (pending[read1Addr] != '0) &&
            !(wbEn && (wbAddr == read1Addr) && (pending[read1Addr] == PEND_W'(1)));
      hz2 = (read2Addr != Mips_Type_RegAddr_Zero) && (pending[read2Addr] != '0) &&
            !(wbEn && (wbAddr == read2Addr) && (pending[read2Addr] == PEND_W'(1)));
      stall = hz1 | hz2;
   end

   // NOTE: every variable assigned in this block gets a default before the
   // loop, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      inc     = '0;
      dec     = '0;
      sat_hit = '0;
      for (int r = 1; r < REG_COUNT; r++) begin
         inc[r]     = issue && !stall && writeEn && (writeAddr == RegAddr_T'(r));
         dec[r]     = wbEn && (wbAddr == RegAddr_T'(r)) && (pending[r] != '0);
         sat_hit[r] = inc[r] && !dec[r] && (pending[r] == PEND_MAX);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every counter
   // samples the same pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < REG_COUNT; r++) pending[r] <= '0;
         overflow <= 1'b0;
      end else begin
         for (int r = 1; r < REG_COUNT; r++) begin
            case ({inc[r], dec[r]})
               2'b10: if (pending[r] != PEND_MAX) pending[r] <= pending[r] + 1'b1;
               2'b01: pending[r] <= pending[r] - 1'b1;
               default: ;  // idle, or issue and commit cancel out
            endcase
         end
         if (|sat_hit) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/mips_datapath_register_file.sv
// -----------------------------------------------------------------------------
// mips_datapath_register_file
//   Architectural 32x32 register file: two combinational reads with
//   write-through bypass from writeback, one write per cycle, plus the
//   pending-write scoreboard that raises stall on RAW hazards.
//   Ports:
//     clock, reset_n - rising-edge clock, async active-low reset
//     bus (slave)    - RegPorts bundle, issue, writeback commit in;
//                      read data, stall, overflow, writeback source out
// -----------------------------------------------------------------------------
module mips_datapath_register_file
   import mips_datapath_register_file_pkg::*;
(
   input logic                           clock,
   input logic                           reset_n,
   mips_datapath_register_file_if.slave  bus
);

   RegPorts_T req;
   Word_T     regs [REG_COUNT];

   assign req          = Mips_Type_RegPorts_unpack(bus.ports);
   assign bus.writeSrc = req.writeSrc;

   // Register 0 reads as zero; a commit to the addressed register this cycle
   // is forwarded so decode sees it without waiting for the edge.
   function automatic Word_T bypass_read(
      input RegAddr_T addr,
      input Word_T    stored,
      input logic     wb_en,
      input RegAddr_T wb_addr,
      input Word_T    wb_data
   );
      if (addr == Mips_Type_RegAddr_Zero) return '0;
      if (wb_en && (wb_addr == addr))     return wb_data;
      return stored;
   endfunction

   always_comb begin
      bus.rd1Data = bypass_read(req.read1Addr, regs[req.read1Addr],
                                bus.wbEn, bus.wbAddr, bus.wbData);
      bus.rd2Data = bypass_read(req.read2Addr, regs[req.read2Addr],
                                bus.wbEn, bus.wbAddr, bus.wbData);
   end

   // NOTE: the storage array is reset on purpose: software may read a
   // register before writing it and must see 0. A reset array is built from
   // flops, which is what a 32-entry multi-read file uses anyway.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
      end else if (bus.wbEn && (bus.wbAddr != Mips_Type_RegAddr_Zero)) begin
         regs[bus.wbAddr] <= bus.wbData;
      end
   end

   mips_datapath_register_scoreboard #(
      .PEND_W (PEND_W)
   ) u_scoreboard (
      .clock     (clock),
      .reset_n   (reset_n),
      .read1Addr (req.read1Addr),
      .read2Addr (req.read2Addr),
      .writeAddr (req.writeAddr),
      .writeEn   (req.writeEn),
      .issue     (bus.issue),
      .wbEn      (bus.wbEn),
      .wbAddr    (bus.wbAddr),
      .stall     (bus.stall),
      .overflow  (bus.overflow)
   );

endmodule

// File: doc/mips_datapath_register_file.md
Name: mips_datapath_register_file

Overview:
- Consumer end of the RegPorts bundle: the architectural 32x32 register file that answers the read/write port requests produced in decode.
- Serves two combinational reads per cycle with write-through bypass from the writeback port.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between decode (ports, issue) and writeback (commit data).

Parameters:
- WORD_W, 32, data width of each register.
- REG_COUNT, 32, number of architectural registers; address width is log2(REG_COUNT)=5.
- PEND_W, 2, width of the per-register in-flight write counter (max 3 outstanding writes per register).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ports  input  RegPorts_W  RegPorts bundle from decode: read1Addr, read2Addr, writeAddr, writeData source, writeEn.
- issue  input  1  decode instruction leaves decode this cycle; honoured only when stall=0.
- wbEn  input  1  writeback commit valid.
- wbAddr  input  5  writeback destination register.
- wbData  input  WORD_W  writeback value.
- rd1Data  output  WORD_W  value of read1Addr.
- rd2Data  output  WORD_W  value of read2Addr.
- stall  output  1  RAW hazard on a read address; decode must hold.
- overflow  output  1  sticky: an issue hit a saturated pending counter.

Behaviour:
- Reset (async, reset_n=0): all registers 0, all pending counters 0, overflow 0. Outputs are combinational, so rd1Data=rd2Data=0 and stall=0 while in reset.
- Register 0 is hardwired:
  - reads return 0;
  - writes to address 0 are ignored;
  - pending[0] never increments;
  - address 0 never stalls.
- Write: on rising clock edge with wbEn=1 and wbAddr!=0, reg[wbAddr] <= wbData.
- Read (combinational, zero latency):
  - if wbEn and wbAddr==rdXAddr and rdXAddr!=0, rdXData=wbData (bypass);
  - else rdXData=reg[rdXAddr].
- Scoreboard, evaluated per register r each cycle:
  - inc = issue & !stall & writeEn & writeAddr==r & r!=0.
  - dec = wbEn & wbAddr==r & r!=0 & pending[r]!=0.
  - inc & dec: no change.
  - inc only: +1, saturating at 2^PEND_W-1. An inc while already saturated sets overflow and the count stays saturated.
  - dec only: -1.
  - wbEn to a register with pending=0: data is still written, counter unchanged (no underflow).
- Stall, combinational:
  - stall = hz1 | hz2, where hzX = rdXAddr!=0 & pending[rdXAddr]!=0 & !(wbEn & wbAddr==rdXAddr & pending[rdXAddr]==1).
  - The last outstanding write being committed this cycle releases the stall in the same cycle, and the bypass supplies its data.
- stall does not depend on issue, so there is no combinational loop.
- writeData source in the bundle is passed through untouched (not used here; the writeback mux consumes it).
- Reset mid-operation clears the scoreboard immediately. Any later wbEn for a pre-reset instruction writes data but does not decrement.
- overflow clears only on reset.

Decomposition:
- Shared package Mips/Type:
  - RegPorts field widths and pack/unpack macros (reuse Mips_Type_RegPorts_unpack);
  - RegAddr_T (5-bit);
  - Word_T;
  - constant Mips_Type_RegAddr_Zero.
- One natural sub-module: mips_datapath_register_scoreboard. It holds the pending counters and produces stall and overflow. Its inputs are read/write addresses, issue, wbEn and wbAddr.
- The top level holds the storage array and the bypass muxes.

Test Plan:
- Reset then read: reset_n pulse, read1Addr=5, read2Addr=0 -> rd1Data=0, rd2Data=0, stall=0.
- Write then read: wbEn=1, wbAddr=3, wbData=0xDEADBEEF, read1Addr=3 in the same cycle -> rd1Data=0xDEADBEEF via bypass. Next cycle with wbEn=0 -> still 0xDEADBEEF from storage.
- Register zero: wbEn, wbAddr=0, wbData=0xFFFFFFFF; issue with writeEn, writeAddr=0; then read 0 -> rd1Data=0, stall=0.
- RAW stall:
  - issue with writeEn, writeAddr=7;
  - next cycle read1Addr=7 -> stall=1 held for 3 cycles;
  - cycle 4: wbEn, wbAddr=7, wbData=0x1234 -> stall=0 and rd1Data=0x1234 in that cycle.
- Multiple in flight: two issues writing r9, then one wb to r9 -> stall still 1 on read of r9. Second wb -> stall=0.
- Saturation and reset: four issues writing r2 with no writeback -> overflow=1 after the fourth. Assert reset_n=0 mid-cycle -> overflow=0 and stall=0 asynchronously.
